// File: rtl/mp_link_pkg.sv
// Shared constants for the two-board multiplayer link: protocol characters,
// link state encoding and the default peer timeout.
package mp_link_pkg;

  // Protocol characters, shared with the transmit side.
  localparam logic [7:0] CHAR_READY = 8'h52;  // 'R'
  localparam logic [7:0] CHAR_LOST  = 8'h4C;  // 'L'

  // Default number of cycles without an 'R' before the ready count is dropped.
  localparam int unsigned PEER_TIMEOUT_DEFAULT = 50_000_000;

  // Link state encoding, also exported on link_state for debug LEDs.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_PEER = 3'd1,
    ST_PLAYING   = 3'd2,
    ST_WON       = 3'd3,
    ST_LOST      = 3'd4
  } link_state_e;

  // Increment an 8-bit count, sticking at 0xFF instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = v;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mp_link_timeout.sv
// Free-running cycle counter with synchronous clear. While enabled it counts
// 0..LIMIT-1; on the cycle it sits at LIMIT-1 it pulses expire and wraps to 0.
module mp_link_timeout #(
  parameter int unsigned LIMIT = 10,
  parameter int unsigned W     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expire
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;
  logic         at_last_s;

  assign at_last_s = (cnt_q == LAST);

  // Next count and expire pulse; clear wins over counting.
  always_comb begin
    cnt_d  = cnt_q;
    expire = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (at_last_s) begin
        cnt_d  = '0;
        expire = 1'b1;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mp_link_rx.sv
// Receive-side decoder for the multiplayer link. Drains the UART receive FIFO
// one byte per cycle, decodes the peer's 'R' (ready) and 'L' (lost) characters
// and runs the match handshake: peer ready detection, game start pulse and
// victory flag.
// Optional build macro MP_LINK_ERRCNT_EN adds err_cnt, a saturating count of
// unexpected bytes seen outside IDLE.
module mp_link_rx
  import mp_link_pkg::*;
#(
  parameter int unsigned READY_COUNT  = 4,
  parameter int unsigned PEER_TIMEOUT = PEER_TIMEOUT_DEFAULT,
  parameter int unsigned TO_W         = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  input  logic       multiplayer,
  input  logic       player_ready,
  input  logic       game_over,
  output logic       rd_uart,
  output logic       peer_seen,
  output logic       game_start,
  output logic       victory,
  output logic [2:0] link_state
`ifdef MP_LINK_ERRCNT_EN
  ,
  output logic [7:0] err_cnt
`endif
);

  localparam int unsigned RC_W = $clog2(READY_COUNT + 1);
  localparam logic [RC_W-1:0] RC_MAX = RC_W'(READY_COUNT);

  link_state_e     state_q;
  link_state_e     state_d;
  logic [RC_W-1:0] rdy_cnt_q;
  logic [RC_W-1:0] rdy_cnt_d;
  logic            pr_q;
  logic            victory_q;
  logic            victory_d;
  logic            game_start_q;
  logic            game_start_d;
  logic            peer_seen_q;
  logic            peer_seen_d;

  logic            pop_s;
  logic            byte_r_s;
  logic            byte_l_s;
  logic            byte_x_s;
  logic            pr_rise_s;
  logic            to_en_s;
  logic            to_clr_s;
  logic            to_expire_s;

  // A byte is taken whenever one is available; nothing is held back.
  assign pop_s     = ~rx_empty & ~rst;
  assign rd_uart   = pop_s;
  assign byte_r_s  = pop_s & (r_data == CHAR_READY);
  assign byte_l_s  = pop_s & (r_data == CHAR_LOST);
  assign byte_x_s  = pop_s & ~byte_r_s & ~byte_l_s;
  assign pr_rise_s = player_ready & ~pr_q;

  // The timeout only runs while waiting for the peer; any 'R', or anything
  // that is about to pull the FSM out of WAIT_PEER, restarts it from zero.
  assign to_en_s  = (state_q == ST_WAIT_PEER) & ~byte_r_s;
  assign to_clr_s = (state_q != ST_WAIT_PEER) | byte_r_s | ~multiplayer | ~player_ready;

  mp_link_timeout #(
    .LIMIT (PEER_TIMEOUT),
    .W     (TO_W)
  ) u_peer_timeout (
    .clk    (clk),
    .rst    (rst),
    .en     (to_en_s),
    .clr    (to_clr_s),
    .expire (to_expire_s)
  );

  // Handshake FSM next state, ready count and victory flag.
  always_comb begin
    state_d      = state_q;
    rdy_cnt_d    = rdy_cnt_q;
    victory_d    = victory_q;
    game_start_d = 1'b0;
    if (!multiplayer) begin
      state_d   = ST_IDLE;
      rdy_cnt_d = '0;
      victory_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          rdy_cnt_d = '0;
          victory_d = 1'b0;
          if (player_ready) begin
            state_d = ST_WAIT_PEER;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT_PEER: begin
          // Withdrawing the local player aborts the wait, even if this very
          // byte would have completed the ready sequence.
          if (!player_ready) begin
            state_d   = ST_IDLE;
            rdy_cnt_d = '0;
          end else begin
            if (byte_r_s) begin
              if (rdy_cnt_q == RC_MAX) begin
                rdy_cnt_d = rdy_cnt_q;
              end else begin
                rdy_cnt_d = rdy_cnt_q + RC_W'(1);
              end
            end else if (byte_l_s | byte_x_s | to_expire_s) begin
              rdy_cnt_d = '0;
            end else begin
              rdy_cnt_d = rdy_cnt_q;
            end
            if (rdy_cnt_d == RC_MAX) begin
              state_d      = ST_PLAYING;
              game_start_d = 1'b1;
            end else begin
              state_d = ST_WAIT_PEER;
            end
          end
        end
        ST_PLAYING: begin
          // A local loss outranks a simultaneous 'L' from the peer.
          if (game_over) begin
            state_d = ST_LOST;
          end else if (byte_l_s) begin
            state_d   = ST_WON;
            victory_d = 1'b1;
          end else begin
            state_d = ST_PLAYING;
          end
        end
        ST_WON, ST_LOST: begin
          if (pr_rise_s) begin
            state_d   = ST_WAIT_PEER;
            rdy_cnt_d = '0;
            victory_d = 1'b0;
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          rdy_cnt_d = '0;
          victory_d = 1'b0;
        end
      endcase
    end
    peer_seen_d = (state_d == ST_PLAYING) |
                  ((state_d == ST_WAIT_PEER) & (rdy_cnt_d != '0));
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rdy_cnt_q    <= '0;
      pr_q         <= 1'b0;
      victory_q    <= 1'b0;
      game_start_q <= 1'b0;
      peer_seen_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rdy_cnt_q    <= rdy_cnt_d;
      pr_q         <= player_ready;
      victory_q    <= victory_d;
      game_start_q <= game_start_d;
      peer_seen_q  <= peer_seen_d;
    end
  end

  assign link_state = state_q;
  assign peer_seen  = peer_seen_q;
  assign game_start = game_start_q;
  assign victory    = victory_q;

`ifdef MP_LINK_ERRCNT_EN
  logic [7:0] err_cnt_q;
  logic [7:0] err_cnt_d;

  // Unexpected-byte count; restarts on every entry to WAIT_PEER.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (!multiplayer) begin
      err_cnt_d = 8'd0;
    end else if ((state_d == ST_WAIT_PEER) && (state_q != ST_WAIT_PEER)) begin
      err_cnt_d = 8'd0;
    end else if (byte_x_s && (state_q != ST_IDLE)) begin
      err_cnt_d = sat_inc8(err_cnt_q);
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_mp_link_rx.sv
// Self-checking bench for mp_link_rx: directed handshake scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_mp_link_rx;

  localparam int RC = 4;
  localparam int PT = 10;

  localparam int M_IDLE    = 0;
  localparam int M_WAIT    = 1;
  localparam int M_PLAYING = 2;
  localparam int M_WON     = 3;
  localparam int M_LOST    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_empty = 1'b1;
  logic [7:0] r_data = 8'h00;
  logic       multiplayer = 1'b0;
  logic       player_ready = 1'b0;
  logic       game_over = 1'b0;
  logic       rd_uart;
  logic       peer_seen;
  logic       game_start;
  logic       victory;
  logic [2:0] link_state;
`ifdef MP_LINK_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  always #5 clk = ~clk;

  mp_link_rx #(
    .READY_COUNT  (RC),
    .PEER_TIMEOUT (PT),
    .TO_W         (26)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_empty     (rx_empty),
    .r_data       (r_data),
    .multiplayer  (multiplayer),
    .player_ready (player_ready),
    .game_over    (game_over),
    .rd_uart      (rd_uart),
    .peer_seen    (peer_seen),
    .game_start   (game_start),
    .victory      (victory),
    .link_state   (link_state)
`ifdef MP_LINK_ERRCNT_EN
    ,
    .err_cnt      (err_cnt)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: match phase, current run of consecutive 'R's, quiet
  // cycles since the last 'R', and the flags the game logic should see.
  int m_state  = M_IDLE;
  int m_streak = 0;
  int m_quiet  = 0;
  int m_err    = 0;
  bit m_vic    = 1'b0;
  bit m_gs     = 1'b0;
  bit m_prev_pr = 1'b0;
  bit m_valid  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void enter_wait();
    m_state  = M_WAIT;
    m_streak = 0;
    m_quiet  = 0;
    m_err    = 0;
    m_vic    = 1'b0;
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  function automatic void model_step();
    bit pop, br, bl, bx, rise;
    int prev;
    pop  = !rx_empty && !rst;
    br   = pop && (r_data == 8'h52);
    bl   = pop && (r_data == 8'h4C);
    bx   = pop && !br && !bl;
    rise = player_ready && !m_prev_pr;
    prev = m_state;
    m_gs = 1'b0;
    m_valid = 1'b1;
    if (rst) begin
      m_state = M_IDLE; m_streak = 0; m_quiet = 0; m_vic = 1'b0; m_err = 0; m_prev_pr = 1'b0;
    end else begin
      m_prev_pr = player_ready;
      if (bx && prev != M_IDLE && m_err < 255) m_err++;
      if (!multiplayer) begin
        m_state = M_IDLE; m_streak = 0; m_quiet = 0; m_vic = 1'b0; m_err = 0;
      end else begin
        case (prev)
          M_IDLE: if (player_ready) enter_wait();
          M_WAIT: begin
            if (!player_ready) begin
              m_state = M_IDLE; m_streak = 0; m_quiet = 0;
            end else begin
              if (br) begin
                m_streak++;
                m_quiet = 0;
              end else begin
                if (bl || bx) m_streak = 0;
                if (m_quiet == PT - 1) begin
                  m_quiet = 0;
                  m_streak = 0;
                end else begin
                  m_quiet++;
                end
              end
              if (m_streak >= RC) begin
                m_state = M_PLAYING;
                m_gs = 1'b1;
              end
            end
          end
          M_PLAYING: begin
            if (game_over) m_state = M_LOST;
            else if (bl) begin
              m_state = M_WON;
              m_vic = 1'b1;
            end
          end
          M_WON, M_LOST: if (rise) enter_wait();
          default: m_state = M_IDLE;
        endcase
      end
    end
  endfunction

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("rd_uart", 32'(rd_uart), 32'(!rx_empty && !rst));
      check("link_state", 32'(link_state), m_state);
      check("game_start", 32'(game_start), 32'(m_gs));
      check("victory", 32'(victory), 32'(m_vic));
      check("peer_seen", 32'(peer_seen),
            32'((m_state == M_WAIT && m_streak != 0) || m_state == M_PLAYING));
`ifdef MP_LINK_ERRCNT_EN
      check("err_cnt", 32'(err_cnt), m_err);
`endif
    end
  end

  // One clock: present a FIFO head (or empty), step the model at the edge.
  task automatic tick(input bit e, input logic [7:0] d);
    rx_empty = e;
    r_data   = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  int burst = 0;

  initial begin
    // Reset
    rst = 1'b1;
    tick(1'b1, 8'h00);
    tick(1'b1, 8'h00);
    rst = 1'b0;
    check("rst_state", 32'(link_state), 32'd0);
    check("rst_peer_seen", 32'(peer_seen), 32'd0);
    check("rst_game_start", 32'(game_start), 32'd0);
    check("rst_victory", 32'(victory), 32'd0);

    // Basic start: four consecutive 'R's
    multiplayer = 1'b1;
    player_ready = 1'b1;
    tick(1'b1, 8'h00);
    check("enter_wait", 32'(link_state), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 8'h52);
      if (i < 3) check("no_early_start", 32'(game_start), 32'd0);
    end
    check("start_pulse", 32'(game_start), 32'd1);
    check("start_state", 32'(link_state), 32'd2);
    tick(1'b1, 8'h00);
    check("start_one_cycle", 32'(game_start), 32'd0);

    // Victory: peer reports loss, then a new round via player_ready 0->1
    tick(1'b0, 8'h4C);
    check("won_state", 32'(link_state), 32'd3);
    check("won_victory", 32'(victory), 32'd1);
    for (int i = 0; i < 3; i++) tick(1'b1, 8'h00);
    player_ready = 1'b0;
    tick(1'b1, 8'h00);
    check("won_hold", 32'(victory), 32'd1);
    player_ready = 1'b1;
    tick(1'b1, 8'h00);
    check("rearm_state", 32'(link_state), 32'd1);
    check("rearm_victory", 32'(victory), 32'd0);

    // Broken sequence: R R A R R R leaves only three in a row
    tick(1'b0, 8'h52);
    tick(1'b0, 8'h52);
    tick(1'b0, 8'h41);
    check("broken_clears", 32'(peer_seen), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 8'h52);
      check("broken_no_start", 32'(game_start), 32'd0);
    end
`ifdef MP_LINK_ERRCNT_EN
    check("broken_err_cnt", 32'(err_cnt), 32'd1);
`endif
    tick(1'b0, 8'h52);
    check("broken_fourth", 32'(game_start), 32'd1);

    // Collision: local loss and peer 'L' together -> LOST, no victory
    game_over = 1'b1;
    tick(1'b0, 8'h4C);
    game_over = 1'b0;
    check("collision_state", 32'(link_state), 32'd4);
    check("collision_victory", 32'(victory), 32'd0);

    // Timeout: one 'R' then PT quiet cycles drops the count
    player_ready = 1'b0;
    tick(1'b1, 8'h00);
    player_ready = 1'b1;
    tick(1'b1, 8'h00);
    tick(1'b0, 8'h52);
    check("to_seen", 32'(peer_seen), 32'd1);
    for (int i = 0; i < PT - 1; i++) tick(1'b1, 8'h00);
    check("to_not_yet", 32'(peer_seen), 32'd1);
    tick(1'b1, 8'h00);
    check("to_expired", 32'(peer_seen), 32'd0);
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h52);
    check("to_three_r", 32'(link_state), 32'd1);
    tick(1'b0, 8'h52);
    check("to_fourth_r", 32'(link_state), 32'd2);
    tick(1'b0, 8'h4C);

    // Mode drop in WON, then reset mid-wait
    multiplayer = 1'b0;
    tick(1'b1, 8'h00);
    check("drop_state", 32'(link_state), 32'd0);
    check("drop_victory", 32'(victory), 32'd0);
    multiplayer = 1'b1;
    tick(1'b1, 8'h00);
    tick(1'b0, 8'h52);
    check("pre_rst_seen", 32'(peer_seen), 32'd1);
    rst = 1'b1;
    tick(1'b0, 8'h52);
    check("rst_mid_state", 32'(link_state), 32'd0);
    check("rst_mid_seen", 32'(peer_seen), 32'd0);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int k;
      logic [7:0] b;
      rst = ($urandom_range(0, 299) == 0);
      if (multiplayer) multiplayer = ($urandom_range(0, 149) != 0);
      else multiplayer = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) player_ready = ~player_ready;
      game_over = ($urandom_range(0, 49) == 0);
      k = $urandom_range(0, 99);
      if (k < 72) b = 8'h52;
      else if (k < 82) b = 8'h4C;
      else b = 8'($urandom_range(0, 255));
      if (burst == 0 && $urandom_range(0, 99) < 3) burst = $urandom_range(5, 14);
      if (burst > 0) begin
        burst--;
        tick(1'b1, b);
      end else begin
        tick(($urandom_range(0, 4) == 0), b);
      end
    end

    rst = 1'b0;
    tick(1'b1, 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
